if_fetch_stage: RTL and testbench

// - Instruction-fetch stage directly upstream of ID: owns the PC, runs the I-mem read handshake, and predicts branches.
// - Supplies instr/pc/prediction to the IF/ID register; ID's flush/redirect corrects mispredictions.
// - Decodes B/JAL targets locally and keeps a 2-bit BHT, so the prediction fed to ID's comparator is consistent.

---
 rtl/if_fetch_stage.sv | 253 +++++++++++++++++++++++++
 tb/tb_if_fetch_stage.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, runs the I-mem read handshake, predecodes B/JAL and predicts.
// Optional feature macro IF_BHT_EN: dynamic 2-bit BHT; when undefined, static backward-taken prediction.
//
// state  | meaning
// FETCH  | read request outstanding (or issuing next cycle); resp accepted combinationally
// HOLD   | fetched word parked in buffer while ID stalls; no request
// SQUASH | request in flight when a redirect arrived; its resp is discarded
module if_fetch_stage #(
  parameter int                width     = 32,
  parameter int                BHT_IDX_W = 6,
  parameter logic [width-1:0]  RESET_PC  = 32'h60
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             IF_stall_i,
  input  logic             IF_imem_resp_i,
  input  logic [width-1:0] IF_imem_rdata_i,
  output logic             IF_imem_read_o,
  output logic [width-1:0] IF_imem_addr_o,
  input  logic             ID_if_id_flush_i,
  input  logic [width-1:0] ID_redirect_pc_i,
  input  logic             ID_bht_upd_i,
  input  logic [width-1:0] ID_bht_pc_i,
  input  logic             ID_br_en_i,
  output logic [width-1:0] IF_instr_o,
  output logic [width-1:0] IF_pc_out_o,
  output logic             IF_br_pred_o,
  output logic             IF_valid_o
);

  localparam logic [width-1:0] NOP_INSTR = 'h13;
  localparam logic [width-1:0] PC_STEP   = 'd4;
  localparam logic [6:0]       OP_BRANCH = 7'b1100011;
  localparam logic [6:0]       OP_JAL    = 7'b1101111;

  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_HOLD   = 2'd1,
    S_SQUASH = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [width-1:0] pc_q, pc_d;
  logic             read_q, read_d;
  logic [width-1:0] redir_q, redir_d;
  logic [width-1:0] buf_instr_q, buf_instr_d;
  logic             buf_pred_q, buf_pred_d;
  logic [width-1:0] buf_next_pc_q, buf_next_pc_d;

  logic             resp_v;
  logic [6:0]       opcode;
  logic [width-1:0] b_imm;
  logic [width-1:0] j_imm;
  logic [width-1:0] br_target;
  logic             br_pred;
  logic             fetch_pred;
  logic [width-1:0] fetch_next_pc;

  // A response only counts while our own request is outstanding.
  assign resp_v = read_q & IF_imem_resp_i;

  // Predecode of the word arriving this cycle
  assign opcode = IF_imem_rdata_i[6:0];
  assign b_imm  = {{(width-12){IF_imem_rdata_i[31]}}, IF_imem_rdata_i[7],
                   IF_imem_rdata_i[30:25], IF_imem_rdata_i[11:8], 1'b0};
  assign j_imm  = {{(width-20){IF_imem_rdata_i[31]}}, IF_imem_rdata_i[19:12],
                   IF_imem_rdata_i[20], IF_imem_rdata_i[30:21], 1'b0};

`ifdef IF_BHT_EN
  localparam int BHT_N = 2**BHT_IDX_W;

  logic [1:0]           bht_q [BHT_N];
  logic [1:0]           bht_d [BHT_N];
  logic [BHT_IDX_W-1:0] lkp_idx;
  logic [BHT_IDX_W-1:0] upd_idx;
  logic                 unused_bht_pc;

  assign lkp_idx       = pc_q[BHT_IDX_W+1:2];
  assign upd_idx       = ID_bht_pc_i[BHT_IDX_W+1:2];
  assign unused_bht_pc = ^{ID_bht_pc_i[width-1:BHT_IDX_W+2], ID_bht_pc_i[1:0]};

  always_comb begin
    bht_d = bht_q;
    if (ID_bht_upd_i) begin
      if (ID_br_en_i && (bht_q[upd_idx] != 2'b11)) begin
        bht_d[upd_idx] = bht_q[upd_idx] + 2'd1;
      end else if (!ID_br_en_i && (bht_q[upd_idx] != 2'b00)) begin
        bht_d[upd_idx] = bht_q[upd_idx] - 2'd1;
      end
    end
  end

  // Lookup reads the registered table, so a same-cycle update is seen next edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < BHT_N; i++) begin
        bht_q[i] <= 2'b01;
      end
    end else begin
      bht_q <= bht_d;
    end
  end

  assign br_pred = bht_q[lkp_idx][1];
`else
  logic unused_bht;

  assign unused_bht = ^{ID_bht_upd_i, ID_bht_pc_i, ID_br_en_i};
  assign br_pred    = b_imm[width-1];
`endif

  always_comb begin
    fetch_pred = 1'b0;
    br_target  = pc_q + b_imm;
    case (opcode)
      OP_BRANCH: fetch_pred = br_pred;
      OP_JAL: begin
        fetch_pred = 1'b1;
        br_target  = pc_q + j_imm;
      end
      default: fetch_pred = 1'b0;
    endcase
    fetch_next_pc = fetch_pred ? br_target : (pc_q + PC_STEP);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Flush outranks stall in every state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: begin
        if (ID_if_id_flush_i) begin
          if (read_q && !IF_imem_resp_i) state_d = S_SQUASH;
        end else if (resp_v && IF_stall_i) begin
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (ID_if_id_flush_i || !IF_stall_i) state_d = S_FETCH;
      end
      S_SQUASH: begin
        if (resp_v) state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_comb begin
    pc_d          = pc_q;
    read_d        = read_q;
    redir_d       = redir_q;
    buf_instr_d   = buf_instr_q;
    buf_pred_d    = buf_pred_q;
    buf_next_pc_d = buf_next_pc_q;
    case (state_q)
      S_FETCH: begin
        if (ID_if_id_flush_i) begin
          if (resp_v) begin
            pc_d   = ID_redirect_pc_i;
            read_d = 1'b0;
          end else if (read_q) begin
            redir_d = ID_redirect_pc_i;
          end else begin
            pc_d   = ID_redirect_pc_i;
            read_d = 1'b1;
          end
        end else if (resp_v) begin
          read_d = 1'b0;
          if (IF_stall_i) begin
            buf_instr_d   = IF_imem_rdata_i;
            buf_pred_d    = fetch_pred;
            buf_next_pc_d = fetch_next_pc;
          end else begin
            pc_d = fetch_next_pc;
          end
        end else begin
          read_d = 1'b1;
        end
      end
      S_HOLD: begin
        if (ID_if_id_flush_i) begin
          pc_d   = ID_redirect_pc_i;
          read_d = 1'b1;
        end else if (!IF_stall_i) begin
          pc_d   = buf_next_pc_q;
          read_d = 1'b1;
        end
      end
      S_SQUASH: begin
        if (resp_v) begin
          pc_d   = ID_if_id_flush_i ? ID_redirect_pc_i : redir_q;
          read_d = 1'b0;
        end else if (ID_if_id_flush_i) begin
          redir_d = ID_redirect_pc_i;
        end
      end
      default: read_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q          <= RESET_PC;
      read_q        <= 1'b0;
      redir_q       <= RESET_PC;
      buf_instr_q   <= NOP_INSTR;
      buf_pred_q    <= 1'b0;
      buf_next_pc_q <= RESET_PC;
    end else begin
      pc_q          <= pc_d;
      read_q        <= read_d;
      redir_q       <= redir_d;
      buf_instr_q   <= buf_instr_d;
      buf_pred_q    <= buf_pred_d;
      buf_next_pc_q <= buf_next_pc_d;
    end
  end

  assign IF_imem_read_o = read_q;
  assign IF_imem_addr_o = pc_q;

  always_comb begin
    IF_instr_o   = NOP_INSTR;
    IF_pc_out_o  = pc_q;
    IF_br_pred_o = 1'b0;
    IF_valid_o   = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (resp_v && !ID_if_id_flush_i) begin
          IF_instr_o   = IF_imem_rdata_i;
          IF_br_pred_o = fetch_pred;
          IF_valid_o   = 1'b1;
        end
      end
      S_HOLD: begin
        if (!ID_if_id_flush_i) begin
          IF_instr_o   = buf_instr_q;
          IF_br_pred_o = buf_pred_q;
          IF_valid_o   = 1'b1;
        end
      end
      default: IF_valid_o = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed scenarios plus a randomized run against a program-order fetch model.
module tb_if_fetch_stage;

  localparam logic [31:0] NOP = 32'h00000013;
  localparam int K_ADDI = 0, K_BEQ = 1, K_JAL = 2, K_JALR = 3, K_OTHER = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, resp, flush, bht_upd, br_en;
  logic [31:0] rdata, redir, bht_pc;
  logic        IF_imem_read_o, IF_br_pred_o, IF_valid_o;
  logic [31:0] IF_imem_addr_o, IF_instr_o, IF_pc_out_o;

  int n_vec = 0;
  int n_err = 0;

  int          mkind [256];
  int          mimm  [256];
  logic [31:0] mword [256];

  always #5 clk = ~clk;

  if_fetch_stage #(.width(32), .BHT_IDX_W(6), .RESET_PC(32'h60)) dut (
    .clk              (clk),
    .rst              (rst),
    .IF_stall_i       (stall),
    .IF_imem_resp_i   (resp),
    .IF_imem_rdata_i  (rdata),
    .IF_imem_read_o   (IF_imem_read_o),
    .IF_imem_addr_o   (IF_imem_addr_o),
    .ID_if_id_flush_i (flush),
    .ID_redirect_pc_i (redir),
    .ID_bht_upd_i     (bht_upd),
    .ID_bht_pc_i      (bht_pc),
    .ID_br_en_i       (br_en),
    .IF_instr_o       (IF_instr_o),
    .IF_pc_out_o      (IF_pc_out_o),
    .IF_br_pred_o     (IF_br_pred_o),
    .IF_valid_o       (IF_valid_o)
  );

  function automatic logic [31:0] enc_addi(input int imm);
    logic [11:0] i;
    i = 12'(imm);
    return {i, 5'd1, 3'b000, 5'd1, 7'b0010011};
  endfunction

  function automatic logic [31:0] enc_beq(input int imm);
    logic [12:0] b;
    b = 13'(imm);
    return {b[12], b[10:5], 5'd2, 5'd1, 3'b000, b[4:1], b[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_jal(input int imm);
    logic [20:0] j;
    j = 21'(imm);
    return {j[20], j[10:1], j[11], j[19:12], 5'd1, 7'b1101111};
  endfunction

  function automatic logic [31:0] enc_jalr();
    return {12'd0, 5'd1, 3'b000, 5'd1, 7'b1100111};
  endfunction

  // Random program: each slot records what it is and its offset, so the model never decodes bits.
  function automatic void build_mem();
    for (int i = 0; i < 256; i++) begin
      int r;
      r = int'($urandom_range(0, 9));
      if (r < 5) begin
        mkind[i] = K_ADDI; mimm[i] = 0; mword[i] = enc_addi(int'($urandom_range(0, 4095)));
      end else if (r < 7) begin
        mkind[i] = K_BEQ; mimm[i] = (int'($urandom_range(0, 32)) - 16) * 4; mword[i] = enc_beq(mimm[i]);
      end else if (r < 8) begin
        mkind[i] = K_JAL; mimm[i] = (int'($urandom_range(0, 32)) - 16) * 4; mword[i] = enc_jal(mimm[i]);
      end else if (r < 9) begin
        mkind[i] = K_JALR; mimm[i] = 0; mword[i] = enc_jalr();
      end else begin
        mkind[i] = K_OTHER; mimm[i] = 0; mword[i] = {12'(r), 5'd1, 3'b010, 5'd1, 7'b0000011};
      end
    end
  endfunction

  function automatic bit model_pred(input int kind, input int imm);
    if (kind == K_JAL) return 1'b1;
    if (kind == K_BEQ) begin
`ifdef IF_BHT_EN
      return 1'b0;
`else
      return (imm < 0);
`endif
    end
    return 1'b0;
  endfunction

  task automatic clear_inputs();
    resp = 0; rdata = 0; stall = 0; flush = 0; redir = 0;
    bht_upd = 0; bht_pc = 0; br_en = 0;
  endtask

  task automatic do_reset();
    rst = 0;
    clear_inputs();
    repeat (2) @(negedge clk);
    rst = 1;
  endtask

  task automatic wait_read(output bit to);
    to = 1;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (IF_imem_read_o === 1'b1) begin
        to = 0;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic give_resp(input logic [31:0] w, output bit to);
    wait_read(to);
    resp = 1; rdata = w;
    #1;
  endtask

  task automatic end_resp();
    @(negedge clk);
    resp = 0;
  endtask

  task automatic test_reset();
    rst = 0;
    clear_inputs();
    @(negedge clk); #1;
    n_vec++; if (IF_imem_read_o !== 1'b0) begin n_err++; $display("FAIL rst_read: got %b want 0", IF_imem_read_o); end
    n_vec++; if (IF_valid_o !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", IF_valid_o); end
    n_vec++; if (IF_instr_o !== NOP) begin n_err++; $display("FAIL rst_instr: got %h want %h", IF_instr_o, NOP); end
    n_vec++; if (IF_pc_out_o !== 32'h60) begin n_err++; $display("FAIL rst_pc_out: got %h want 60", IF_pc_out_o); end
    n_vec++; if (IF_br_pred_o !== 1'b0) begin n_err++; $display("FAIL rst_pred: got %b want 0", IF_br_pred_o); end
    rst = 1; #1;
    n_vec++; if (IF_imem_read_o !== 1'b0) begin n_err++; $display("FAIL rst_release_read: got %b want 0", IF_imem_read_o); end
    @(negedge clk); #1;
    n_vec++; if (IF_imem_read_o !== 1'b1) begin n_err++; $display("FAIL first_read: got %b want 1", IF_imem_read_o); end
    n_vec++; if (IF_imem_addr_o !== 32'h60) begin n_err++; $display("FAIL first_addr: got %h want 60", IF_imem_addr_o); end
    rst = 0; #1;
    n_vec++; if (IF_imem_read_o !== 1'b0) begin n_err++; $display("FAIL midreq_rst_read: got %b want 0", IF_imem_read_o); end
    @(negedge clk);
    rst = 1; resp = 1; rdata = enc_addi(5); #1;
    n_vec++; if (IF_valid_o !== 1'b0) begin n_err++; $display("FAIL late_resp_valid: got %b want 0", IF_valid_o); end
    n_vec++; if (IF_instr_o !== NOP) begin n_err++; $display("FAIL late_resp_instr: got %h want %h", IF_instr_o, NOP); end
    @(negedge clk);
    resp = 0; #1;
    n_vec++; if (IF_imem_read_o !== 1'b1 || IF_imem_addr_o !== 32'h60) begin
      n_err++; $display("FAIL reissue: got read=%b addr=%h want 1/60", IF_imem_read_o, IF_imem_addr_o);
    end
  endtask

  task automatic test_basic();
    bit to;
    logic [31:0] w;
    w = enc_addi(7);
    do_reset();
    wait_read(to);
    n_vec++; if (to || IF_imem_addr_o !== 32'h60) begin n_err++; $display("FAIL basic_addr: got %h to=%b want 60", IF_imem_addr_o, to); end
    repeat (2) @(negedge clk);
    #1;
    n_vec++; if (IF_imem_read_o !== 1'b1) begin n_err++; $display("FAIL basic_read_held: got %b want 1", IF_imem_read_o); end
    resp = 1; rdata = w; #1;
    n_vec++; if (IF_valid_o !== 1'b1) begin n_err++; $display("FAIL basic_valid: got %b want 1", IF_valid_o); end
    n_vec++; if (IF_instr_o !== w) begin n_err++; $display("FAIL basic_instr: got %h want %h", IF_instr_o, w); end
    n_vec++; if (IF_pc_out_o !== 32'h60) begin n_err++; $display("FAIL basic_pc: got %h want 60", IF_pc_out_o); end
    n_vec++; if (IF_br_pred_o !== 1'b0) begin n_err++; $display("FAIL basic_pred: got %b want 0", IF_br_pred_o); end
    end_resp(); #1;
    n_vec++; if (IF_imem_read_o !== 1'b0) begin n_err++; $display("FAIL basic_bubble: got %b want 0", IF_imem_read_o); end
    @(negedge clk); #1;
    n_vec++; if (IF_imem_read_o !== 1'b1 || IF_imem_addr_o !== 32'h64) begin
      n_err++; $display("FAIL basic_next: got read=%b addr=%h want 1/64", IF_imem_read_o, IF_imem_addr_o);
    end
  endtask

  task automatic test_stall();
    bit to;
    logic [31:0] w;
    w = enc_addi(33);
    do_reset();
    wait_read(to);
    stall = 1; resp = 1; rdata = w;
    @(negedge clk);
    resp = 0; rdata = 32'hdeadbeef;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_vec++; if (IF_valid_o !== 1'b1 || IF_instr_o !== w || IF_pc_out_o !== 32'h60 || IF_imem_read_o !== 1'b0) begin
        n_err++; $display("FAIL hold_outputs: got v=%b i=%h pc=%h rd=%b want 1/%h/60/0",
                          IF_valid_o, IF_instr_o, IF_pc_out_o, IF_imem_read_o, w);
      end
      @(negedge clk);
    end
    stall = 0; #1;
    n_vec++; if (IF_valid_o !== 1'b1 || IF_instr_o !== w) begin
      n_err++; $display("FAIL hold_release: got v=%b i=%h want 1/%h", IF_valid_o, IF_instr_o, w);
    end
    @(negedge clk);
    wait_read(to);
    n_vec++; if (to || IF_imem_addr_o !== 32'h64) begin n_err++; $display("FAIL hold_resume: got %h to=%b want 64", IF_imem_addr_o, to); end
  endtask

  task automatic test_flush();
    bit to;
    do_reset();
    wait_read(to);
    flush = 1; redir = 32'h200; #1;
    n_vec++; if (IF_valid_o !== 1'b0) begin n_err++; $display("FAIL flush_valid: got %b want 0", IF_valid_o); end
    @(negedge clk);
    flush = 0; redir = 0; #1;
    n_vec++; if (IF_imem_read_o !== 1'b1 || IF_imem_addr_o !== 32'h60) begin
      n_err++; $display("FAIL squash_held: got read=%b addr=%h want 1/60", IF_imem_read_o, IF_imem_addr_o);
    end
    @(negedge clk);
    resp = 1; rdata = enc_addi(1); #1;
    n_vec++; if (IF_valid_o !== 1'b0 || IF_instr_o !== NOP) begin
      n_err++; $display("FAIL squash_drop: got v=%b i=%h want 0/%h", IF_valid_o, IF_instr_o, NOP);
    end
    end_resp();
    give_resp(enc_addi(2), to);
    n_vec++; if (to || IF_imem_addr_o !== 32'h200) begin n_err++; $display("FAIL redirect_addr: got %h to=%b want 200", IF_imem_addr_o, to); end
    n_vec++; if (IF_valid_o !== 1'b1 || IF_pc_out_o !== 32'h200) begin
      n_err++; $display("FAIL redirect_out: got v=%b pc=%h want 1/200", IF_valid_o, IF_pc_out_o);
    end
    end_resp();
  endtask

  task automatic test_jal();
    bit to;
    do_reset();
    give_resp(enc_jal(32'sh20), to);
    n_vec++; if (to || IF_br_pred_o !== 1'b1) begin n_err++; $display("FAIL jal0_pred: got %b to=%b want 1", IF_br_pred_o, to); end
    end_resp();
    give_resp(enc_jal(-16), to);
    n_vec++; if (to || IF_imem_addr_o !== 32'h80) begin n_err++; $display("FAIL jal_addr80: got %h want 80", IF_imem_addr_o); end
    n_vec++; if (IF_br_pred_o !== 1'b1 || IF_pc_out_o !== 32'h80) begin
      n_err++; $display("FAIL jal_back_pred: got p=%b pc=%h want 1/80", IF_br_pred_o, IF_pc_out_o);
    end
    end_resp();
    give_resp(enc_jal(16), to);
    n_vec++; if (to || IF_imem_addr_o !== 32'h70) begin n_err++; $display("FAIL jal_target70: got %h want 70", IF_imem_addr_o); end
    end_resp();
    give_resp(enc_jalr(), to);
    n_vec++; if (to || IF_imem_addr_o !== 32'h80) begin n_err++; $display("FAIL jalr_addr: got %h want 80", IF_imem_addr_o); end
    n_vec++; if (IF_br_pred_o !== 1'b0) begin n_err++; $display("FAIL jalr_pred: got %b want 0", IF_br_pred_o); end
    end_resp();
    wait_read(to);
    n_vec++; if (to || IF_imem_addr_o !== 32'h84) begin n_err++; $display("FAIL jalr_next: got %h want 84", IF_imem_addr_o); end
  endtask

`ifdef IF_BHT_EN
  task automatic test_bht();
    bit to;
    do_reset();
    give_resp(enc_beq(32'sh40), to);
    n_vec++; if (to || IF_br_pred_o !== 1'b0) begin n_err++; $display("FAIL bht_first_pred: got %b want 0", IF_br_pred_o); end
    end_resp();
    bht_upd = 1; bht_pc = 32'h60; br_en = 1;
    repeat (2) @(negedge clk);
    bht_upd = 0;
    wait_read(to);
    flush = 1; redir = 32'h60;
    @(negedge clk);
    flush = 0;
    give_resp(enc_addi(3), to);
    n_vec++; if (IF_valid_o !== 1'b0) begin n_err++; $display("FAIL bht_squash: got %b want 0", IF_valid_o); end
    end_resp();
    give_resp(enc_beq(32'sh40), to);
    n_vec++; if (to || IF_imem_addr_o !== 32'h60 || IF_br_pred_o !== 1'b1) begin
      n_err++; $display("FAIL bht_second_pred: got addr=%h p=%b want 60/1", IF_imem_addr_o, IF_br_pred_o);
    end
    end_resp();
    wait_read(to);
    n_vec++; if (to || IF_imem_addr_o !== 32'ha0) begin n_err++; $display("FAIL bht_target: got %h want a0", IF_imem_addr_o); end
  endtask
`else
  task automatic test_static_br();
    bit to;
    do_reset();
    bht_upd = 1; bht_pc = 32'h60; br_en = 1;
    give_resp(enc_beq(32'sh40), to);
    n_vec++; if (to || IF_br_pred_o !== 1'b0) begin n_err++; $display("FAIL fwd_beq_pred: got %b want 0", IF_br_pred_o); end
    end_resp();
    bht_pc = 32'h64; br_en = 0;
    give_resp(enc_beq(-32), to);
    n_vec++; if (to || IF_imem_addr_o !== 32'h64) begin n_err++; $display("FAIL fwd_beq_next: got %h want 64", IF_imem_addr_o); end
    n_vec++; if (IF_br_pred_o !== 1'b1) begin n_err++; $display("FAIL back_beq_pred: got %b want 1", IF_br_pred_o); end
    end_resp();
    bht_pc = 32'h44; br_en = 1;
    give_resp(enc_beq(8), to);
    n_vec++; if (to || IF_imem_addr_o !== 32'h44) begin n_err++; $display("FAIL back_beq_target: got %h want 44", IF_imem_addr_o); end
    n_vec++; if (IF_br_pred_o !== 1'b0) begin n_err++; $display("FAIL fwd_beq2_pred: got %b want 0", IF_br_pred_o); end
    end_resp();
    wait_read(to);
    n_vec++; if (to || IF_imem_addr_o !== 32'h48) begin n_err++; $display("FAIL fwd_beq2_next: got %h want 48", IF_imem_addr_o); end
    bht_upd = 0;
  endtask
`endif

  // Random memory latency, stalls, flushes and stray responses; consumed instructions must follow program order.
  task automatic test_random();
    int          consumed = 0;
    int          lat = 0;
    int          idx;
    bit          pending = 0;
    bit          p_read = 0, p_resp = 0;
    bit          ep;
    logic [31:0] p_addr = 0;
    logic [31:0] exp_pc = 32'h60;
    build_mem();
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      resp  = 0;
      rdata = $urandom;
      if (IF_imem_read_o && !pending) begin
        pending = 1;
        lat = int'($urandom_range(0, 3));
      end
      if (pending) begin
        if (lat == 0) begin
          resp = 1; rdata = mword[IF_imem_addr_o[9:2]]; pending = 0;
        end else begin
          lat--;
        end
      end else if ($urandom_range(0, 19) == 0) begin
        resp = 1;
      end
      stall = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 24) == 0);
      redir = {22'd0, 8'($urandom), 2'b00};
      #1;
      if (p_read && !p_resp) begin
        n_vec++; if (IF_imem_read_o !== 1'b1 || IF_imem_addr_o !== p_addr) begin
          n_err++; $display("FAIL req_stable: got read=%b addr=%h want 1/%h", IF_imem_read_o, IF_imem_addr_o, p_addr);
        end
      end
      if (IF_valid_o !== 1'b1) begin
        n_vec++; if (IF_instr_o !== NOP) begin n_err++; $display("FAIL invalid_nop: got %h want %h", IF_instr_o, NOP); end
      end
      if (flush) begin
        n_vec++; if (IF_valid_o !== 1'b0) begin n_err++; $display("FAIL flush_drop: got %b want 0", IF_valid_o); end
        exp_pc = redir;
      end else if (IF_valid_o === 1'b1 && !stall) begin
        idx = int'(exp_pc[9:2]);
        ep  = model_pred(mkind[idx], mimm[idx]);
        n_vec++; if (IF_pc_out_o !== exp_pc) begin n_err++; $display("FAIL rnd_pc: got %h want %h", IF_pc_out_o, exp_pc); end
        n_vec++; if (IF_instr_o !== mword[idx]) begin n_err++; $display("FAIL rnd_instr: got %h want %h", IF_instr_o, mword[idx]); end
        n_vec++; if (IF_br_pred_o !== ep) begin n_err++; $display("FAIL rnd_pred: got %b want %b at %h", IF_br_pred_o, ep, exp_pc); end
        exp_pc = ep ? (exp_pc + 32'(mimm[idx])) : (exp_pc + 32'd4);
        consumed++;
      end
      p_read = IF_imem_read_o;
      p_resp = resp;
      p_addr = IF_imem_addr_o;
      @(negedge clk);
    end
    clear_inputs();
    n_vec++; if (consumed < 200) begin n_err++; $display("FAIL rnd_progress: got %0d instrs want >=200", consumed); end
  endtask

  initial begin
    rst = 0;
    clear_inputs();
    test_reset();
    test_basic();
    test_stall();
    test_flush();
    test_jal();
`ifdef IF_BHT_EN
    test_bht();
`else
    test_static_br();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
